traffic_phase_ctrl: RTL and testbench

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_phase_ctrl.sv | 164 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase controller: Moore FSM with a shared down-counter timer.
// Define TRAFFIC_PED_WALK_EN to build in the pedestrian walk phase.
module traffic_phase_ctrl #(
  parameter int T_MAIN_G  = 8,
  parameter int T_SIDE_G  = 4,
  parameter int T_YEL     = 2,
  parameter int T_ALLRED  = 1,
  parameter int T_WALK    = 3,
  parameter int CNT_W     = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALL_R1 = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
`ifdef TRAFFIC_PED_WALK_EN
    PED    = 3'd6,
`endif
    ALL_R2 = 3'd5
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] YEL = 3'b001;

  localparam logic [CNT_W-1:0] D_MAIN = CNT_W'(T_MAIN_G - 1);
  localparam logic [CNT_W-1:0] D_SIDE = CNT_W'(T_SIDE_G - 1);
  localparam logic [CNT_W-1:0] D_YEL  = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] D_AR   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] D_WALK = CNT_W'(T_WALK - 1);

  function automatic logic [CNT_W-1:0] dur_of(input state_t s);
    case (s)
      MAIN_G:  dur_of = D_MAIN;
      SIDE_G:  dur_of = D_SIDE;
      MAIN_Y,
      SIDE_Y:  dur_of = D_YEL;
      default: dur_of = D_AR;
    endcase
`ifdef TRAFFIC_PED_WALK_EN
    if (s == PED) dur_of = D_WALK;
`endif
  endfunction

  // {main, side}; anything not explicitly a road phase is all-red
  function automatic logic [5:0] lamps_of(input state_t s);
    case (s)
      MAIN_G:  lamps_of = {GRN, RED};
      MAIN_Y:  lamps_of = {YEL, RED};
      SIDE_G:  lamps_of = {RED, GRN};
      SIDE_Y:  lamps_of = {RED, YEL};
      default: lamps_of = {RED, RED};
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             side_pend_q, side_pend_d;
  logic [5:0]       lamps_q, lamps_d;
  logic             timer_expired;
  logic             side_now;
  logic             ped_now;

  assign timer_expired = (timer_q == '0);
  // Requests arriving this cycle count immediately so a resting MAIN_G reacts on the next edge
  assign side_now = side_pend_q | side_car;

`ifdef TRAFFIC_PED_WALK_EN
  logic ped_pend_q, ped_pend_d;
  logic ped_walk_q, ped_ack_q;

  assign ped_now = ped_pend_q | (ped_req & (state_q != PED));
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign ped_now        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_expired ? '0 : timer_q - CNT_W'(1);
    side_pend_d = side_now;
    case (state_q)
      MAIN_G: if (timer_expired && (side_now || ped_now)) state_d = MAIN_Y;
      MAIN_Y: if (timer_expired) state_d = ALL_R1;
      ALL_R1: begin
        if (timer_expired) begin
`ifdef TRAFFIC_PED_WALK_EN
          state_d = ped_now ? PED : SIDE_G;
`else
          state_d = SIDE_G;
`endif
        end
      end
      SIDE_G: if (timer_expired) state_d = SIDE_Y;
      SIDE_Y: if (timer_expired) state_d = ALL_R2;
      ALL_R2: if (timer_expired) state_d = MAIN_G;
`ifdef TRAFFIC_PED_WALK_EN
      PED:    if (timer_expired) state_d = MAIN_G;
`endif
      default: state_d = ALL_R2;
    endcase
    if (state_d != state_q) timer_d = dur_of(state_d);
    if ((state_d == SIDE_G) && (state_q != SIDE_G)) side_pend_d = 1'b0;
    lamps_d = lamps_of(state_d);
  end

`ifdef TRAFFIC_PED_WALK_EN
  always_comb begin
    ped_pend_d = ped_now;
    if ((state_d == PED) && (state_q != PED)) ped_pend_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ped_pend_q <= 1'b0;
      ped_walk_q <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      ped_walk_q <= (state_d == PED);
      ped_ack_q  <= (state_d == PED) && (state_q != PED);
    end
  end

  assign ped_walk = ped_walk_q;
  assign ped_ack  = ped_ack_q;
`else
  assign ped_walk = 1'b0;
  assign ped_ack  = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= MAIN_G;
      timer_q     <= D_MAIN;
      side_pend_q <= 1'b0;
      lamps_q     <= {GRN, RED};
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      side_pend_q <= side_pend_d;
      lamps_q     <= lamps_d;
    end
  end

  assign main_light = lamps_q[5:3];
  assign side_light = lamps_q[2:0];
  assign phase      = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed self-checking bench for traffic_phase_ctrl (default parameters).
// The pedestrian scenario runs only when TRAFFIC_PED_WALK_EN is defined.
module tb_traffic_phase_ctrl;

  logic       clock;
  logic       reset_n;
  logic       side_car;
  logic       ped_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       ped_walk;
  logic       ped_ack;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] prev_ph;

  traffic_phase_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .side_car   (side_car),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .ped_walk   (ped_walk),
    .ped_ack    (ped_ack),
    .phase      (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle's outputs against the expected phase, then drive this cycle's inputs
  task automatic cyc(input logic [2:0] ph, input logic sc, input logic pr);
    logic [2:0] m_exp, s_exp;
    case (ph)
      3'd0:    begin m_exp = 3'b010; s_exp = 3'b100; end
      3'd1:    begin m_exp = 3'b001; s_exp = 3'b100; end
      3'd3:    begin m_exp = 3'b100; s_exp = 3'b010; end
      3'd4:    begin m_exp = 3'b100; s_exp = 3'b001; end
      default: begin m_exp = 3'b100; s_exp = 3'b100; end
    endcase
    chk("phase", 32'(phase), 32'(ph));
    chk("main_light", 32'(main_light), 32'(m_exp));
    chk("side_light", 32'(side_light), 32'(s_exp));
    chk("ped_walk", 32'(ped_walk), 32'(ph == 3'd6));
    chk("ped_ack", 32'(ped_ack), 32'((ph == 3'd6) && (prev_ph != 3'd6)));
    chk("lamp_onehot", {30'd0, $onehot(main_light), $onehot(side_light)}, 32'd3);
    chk("no_conflict", 32'((main_light != 3'b100) && (side_light != 3'b100)), 32'd0);
    prev_ph  = ph;
    side_car = sc;
    ped_req  = pr;
    @(negedge clock);
  endtask

  task automatic run(input logic [2:0] ph, input int n);
    for (int i = 0; i < n; i++) cyc(ph, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_main"}, 32'(main_light), 32'b010);
    chk({tag, "_side"}, 32'(side_light), 32'b100);
    chk({tag, "_walk"}, 32'(ped_walk), 32'd0);
    chk({tag, "_ack"}, 32'(ped_ack), 32'd0);
  endtask

  // Hold reset across a rising edge, release on a falling edge: cycle 0 follows
  task automatic do_reset();
    side_car = 1'b0;
    ped_req  = 1'b0;
    reset_n  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_reset_values("reset_hold");
    reset_n = 1'b1;
    prev_ph = 3'd0;
  endtask

  initial begin
    reset_n  = 1'b0;
    side_car = 1'b0;
    ped_req  = 1'b0;
    prev_ph  = 3'd0;

    // Idle for 50 cycles, then a side car while resting: MAIN_Y on the next edge
    do_reset();
    run(3'd0, 50);
    $display("idle50 + rest side_car: checks so far %0d", n_cmp);
    cyc(3'd0, 1'b1, 1'b0);
    run(3'd1, 2); run(3'd2, 1); run(3'd3, 4); run(3'd4, 2); run(3'd5, 1);
    run(3'd0, 10);
    $display("rest side_car sequence done: checks so far %0d", n_cmp);

    // Side car at cycle 2 honours the 8-cycle minimum green; car at ALL_R1->SIDE_G is cleared
    do_reset();
    run(3'd0, 2);
    cyc(3'd0, 1'b1, 1'b0);
    run(3'd0, 5);
    run(3'd1, 2);
    cyc(3'd2, 1'b1, 1'b0);
    run(3'd3, 4); run(3'd4, 2); run(3'd5, 1);
    run(3'd0, 12);
    $display("min green sequence done: checks so far %0d", n_cmp);

    // Reset asserted mid SIDE_G with a pending side request
    do_reset();
    cyc(3'd0, 1'b1, 1'b0);
    run(3'd0, 7);
    run(3'd1, 2); run(3'd2, 1);
    cyc(3'd3, 1'b1, 1'b0);
    cyc(3'd3, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    prev_ph = 3'd0;
    run(3'd0, 20);
    $display("async reset in SIDE_G done: checks so far %0d", n_cmp);

`ifdef TRAFFIC_PED_WALK_EN
    // Pedestrian and car together: PED first, side served on the next MAIN_G exit
    do_reset();
    run(3'd0, 3);
    cyc(3'd0, 1'b1, 1'b1);
    run(3'd0, 4);
    run(3'd1, 2); run(3'd2, 1);
    run(3'd6, 1);
    cyc(3'd6, 1'b0, 1'b1);
    run(3'd6, 1);
    run(3'd0, 8);
    run(3'd1, 2); run(3'd2, 1); run(3'd3, 4); run(3'd4, 2); run(3'd5, 1);
    run(3'd0, 10);
    $display("pedestrian sequence done: checks so far %0d", n_cmp);
`else
    // Without the pedestrian feature the button is ignored
    do_reset();
    for (int i = 0; i < 16; i++) cyc(3'd0, 1'b0, 1'b1);
    run(3'd0, 4);
    $display("ped_req ignored done: checks so far %0d", n_cmp);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
